// File: rtl/pipelined_bla_sub16.sv
// Four-stage 16-bit subtractor: each stage resolves one 4-bit borrow-lookahead slice.
// A single advance signal stalls every stage when the output is valid and not taken.
module pipelined_bla_sub16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        bin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] diff,
  output logic        bout,
  output logic        ovf
);

  // Returns {borrow_out, diff[3:0]}; every borrow is a flat lookahead term.
  function automatic logic [4:0] slice4(input logic [3:0] x, input logic [3:0] y,
                                        input logic c0);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = ~x & y;
    p    = ~(x ^ y);
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return {c[4], x ^ y ^ c[3:0]};
  endfunction

  logic        adv;

  logic        s0_v_q, s0_br_q, s0_a15_q, s0_b15_q;
  logic [3:0]  s0_diff_q;
  logic [11:0] s0_a_q, s0_b_q;

  logic        s1_v_q, s1_br_q, s1_a15_q, s1_b15_q;
  logic [7:0]  s1_diff_q;
  logic [7:0]  s1_a_q, s1_b_q;

  logic        s2_v_q, s2_br_q, s2_a15_q, s2_b15_q;
  logic [11:0] s2_diff_q;
  logic [3:0]  s2_a_q, s2_b_q;

  logic        s3_v_q, s3_br_q, s3_ovf_q;
  logic [15:0] s3_diff_q;

  logic [4:0]  s0_d, s1_d, s2_d, s3_d;
  logic        s3_ovf_d;

  assign adv      = !s3_v_q | out_ready;
  assign in_ready = adv;

  assign s0_d = slice4(a[3:0], b[3:0], bin);
  assign s1_d = slice4(s0_a_q[3:0], s0_b_q[3:0], s0_br_q);
  assign s2_d = slice4(s1_a_q[3:0], s1_b_q[3:0], s1_br_q);
  assign s3_d = slice4(s2_a_q, s2_b_q, s2_br_q);

  // Sign bits travel alongside so overflow needs no operand bits from S3 inputs.
  assign s3_ovf_d = (s2_a15_q ^ s2_b15_q) & (s3_d[3] ^ s2_a15_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_v_q    <= 1'b0;
      s0_br_q   <= 1'b0;
      s0_a15_q  <= 1'b0;
      s0_b15_q  <= 1'b0;
      s0_diff_q <= '0;
      s0_a_q    <= '0;
      s0_b_q    <= '0;
      s1_v_q    <= 1'b0;
      s1_br_q   <= 1'b0;
      s1_a15_q  <= 1'b0;
      s1_b15_q  <= 1'b0;
      s1_diff_q <= '0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s2_v_q    <= 1'b0;
      s2_br_q   <= 1'b0;
      s2_a15_q  <= 1'b0;
      s2_b15_q  <= 1'b0;
      s2_diff_q <= '0;
      s2_a_q    <= '0;
      s2_b_q    <= '0;
      s3_v_q    <= 1'b0;
      s3_br_q   <= 1'b0;
      s3_ovf_q  <= 1'b0;
      s3_diff_q <= '0;
    end else if (adv) begin
      s0_v_q    <= in_valid;
      s0_br_q   <= s0_d[4];
      s0_diff_q <= s0_d[3:0];
      s0_a_q    <= a[15:4];
      s0_b_q    <= b[15:4];
      s0_a15_q  <= a[15];
      s0_b15_q  <= b[15];

      s1_v_q    <= s0_v_q;
      s1_br_q   <= s1_d[4];
      s1_diff_q <= {s1_d[3:0], s0_diff_q};
      s1_a_q    <= s0_a_q[11:4];
      s1_b_q    <= s0_b_q[11:4];
      s1_a15_q  <= s0_a15_q;
      s1_b15_q  <= s0_b15_q;

      s2_v_q    <= s1_v_q;
      s2_br_q   <= s2_d[4];
      s2_diff_q <= {s2_d[3:0], s1_diff_q};
      s2_a_q    <= s1_a_q[7:4];
      s2_b_q    <= s1_b_q[7:4];
      s2_a15_q  <= s1_a15_q;
      s2_b15_q  <= s1_b15_q;

      s3_v_q    <= s2_v_q;
      s3_br_q   <= s3_d[4];
      s3_diff_q <= {s3_d[3:0], s2_diff_q};
      s3_ovf_q  <= s3_ovf_d;
    end
  end

  assign out_valid = s3_v_q;
  assign diff      = s3_diff_q;
  assign bout      = s3_br_q;
  assign ovf       = s3_ovf_q;

endmodule
